// File: rtl/led_pkg.sv
// led_pkg -- shared definitions for the LED breathing block.
//   breath_state_t : FSM state encoding (IDLE, RISE, HOLD_HI, FALL, HOLD_LO)
//   off_level()    : pin level that keeps the LED dark for a given polarity
//   duty_max()     : largest duty value (fully lit except one clock) for a PWM width
package led_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RISE    = 3'd1,
    HOLD_HI = 3'd2,
    FALL    = 3'd3,
    HOLD_LO = 3'd4
  } breath_state_t;

  localparam int DEFAULT_PWM_BITS = 8;

  function automatic logic off_level(input int active_low);
    return (active_low != 0);
  endfunction

  function automatic int duty_max(input int bits);
    return (1 << bits) - 1;
  endfunction

endpackage

// File: rtl/led_pwm_gen.sv
// led_pwm_gen -- free-running PWM counter, duty register and pin driver.
//   clk       : clock (rising edge)
//   rst_n     : synchronous active-low reset
//   i_en      : run enable; low clears counter/duty and parks the pin off
//   i_shadow  : next duty value, sampled only when the counter wraps
//   o_duty    : duty value applied to the current period
//   o_led     : registered pin drive (lit XOR active-low polarity)
module led_pwm_gen
  import led_pkg::*;
#(
  parameter int PWM_BITS   = DEFAULT_PWM_BITS,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_en,
  input  logic [PWM_BITS-1:0] i_shadow,
  output logic [PWM_BITS-1:0] o_duty,
  output logic                o_led
);

  localparam logic [PWM_BITS-1:0] MAX = PWM_BITS'(duty_max(PWM_BITS));
  localparam logic                OFF = off_level(ACTIVE_LOW);

  logic [PWM_BITS-1:0] r_cnt;
  logic [PWM_BITS-1:0] r_duty;
  logic                r_led;
  logic                w_lit;
  logic                w_wrap;

  assign w_lit  = (r_cnt < r_duty);
  assign w_wrap = (r_cnt == MAX);

  // Duty is reloaded on the same edge the counter returns to 0, so a whole
  // period always runs against a single duty value.
  always_ff @(posedge clk) begin
    if (!rst_n || !i_en) begin
      r_cnt  <= '0;
      r_duty <= '0;
      r_led  <= OFF;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (w_wrap) begin
        r_duty <= i_shadow;
      end
      r_led <= w_lit ^ OFF;
    end
  end

  assign o_duty = r_duty;
  assign o_led  = r_led;

endmodule

// File: rtl/led_breath.sv
// led_breath -- LED "breathing" controller: ramps a PWM duty up and down one
// STEP per tick, with optional dwell at each extreme.
//   clk        : clock (rising edge)
//   rst_n      : synchronous active-low reset
//   en         : breathing enable; low returns everything to idle/off
//   tick_in    : one-cycle step pulse (held high = one step per clock)
//   led_out    : registered PWM pin drive
//   duty       : duty value currently applied
//   cycle_done : one-clock pulse after the fall reaches zero
// Build option: define LED_BREATH_HOLD_EN to add HOLD_HI/HOLD_LO dwell states
// lasting HOLD_TICKS ticks each.
module led_breath
  import led_pkg::*;
#(
  parameter int PWM_BITS   = DEFAULT_PWM_BITS,
  parameter int STEP       = 1,
  parameter int HOLD_TICKS = 4,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                tick_in,
  output logic                led_out,
  output logic [PWM_BITS-1:0] duty,
  output logic                cycle_done
);

  // Arithmetic is one bit wider so the rise can detect overshoot past MAX.
  localparam logic [PWM_BITS:0]   MAX_W  = (PWM_BITS+1)'(duty_max(PWM_BITS));
  localparam logic [PWM_BITS:0]   STEP_W = (PWM_BITS+1)'(STEP);
  localparam logic [PWM_BITS-1:0] MAX_N  = PWM_BITS'(duty_max(PWM_BITS));
  localparam logic [PWM_BITS-1:0] STEP_N = PWM_BITS'(STEP);

  breath_state_t       r_state;
  breath_state_t       w_state_next;
  logic [PWM_BITS-1:0] r_shadow;
  logic [PWM_BITS-1:0] w_shadow_next;
  logic                r_cycle_done;
  logic                w_cycle_done_next;
  logic [PWM_BITS:0]   w_sum;
  logic                w_rise_top;
  logic                w_fall_bottom;

  assign w_sum         = {1'b0, r_shadow} + STEP_W;
  assign w_rise_top    = (w_sum >= MAX_W);
  assign w_fall_bottom = ({1'b0, r_shadow} <= STEP_W);

`ifdef LED_BREATH_HOLD_EN
  localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  logic [HOLD_W-1:0] r_hold_cnt;
  logic              w_hold_last;
  logic              w_in_hold;

  assign w_hold_last = (r_hold_cnt == HOLD_W'(HOLD_TICKS - 1));
  assign w_in_hold   = (r_state == HOLD_HI) || (r_state == HOLD_LO);

  // Counts ticks spent in a hold state; clears on the exiting tick so the
  // next hold starts from 0.
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      r_hold_cnt <= '0;
    end else if (tick_in && w_in_hold) begin
      r_hold_cnt <= w_hold_last ? '0 : r_hold_cnt + 1'b1;
    end
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    if (!en) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: w_state_next = RISE;
        RISE: begin
          if (tick_in && w_rise_top) begin
`ifdef LED_BREATH_HOLD_EN
            w_state_next = HOLD_HI;
`else
            w_state_next = FALL;
`endif
          end
        end
        FALL: begin
          if (tick_in && w_fall_bottom) begin
`ifdef LED_BREATH_HOLD_EN
            w_state_next = HOLD_LO;
`else
            w_state_next = RISE;
`endif
          end
        end
`ifdef LED_BREATH_HOLD_EN
        HOLD_HI: if (tick_in && w_hold_last) w_state_next = FALL;
        HOLD_LO: if (tick_in && w_hold_last) w_state_next = RISE;
`endif
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Output logic: shadow duty update and end-of-breath pulse request
  always_comb begin
    w_shadow_next     = r_shadow;
    w_cycle_done_next = 1'b0;
    if (!en) begin
      w_shadow_next = '0;
    end else if (tick_in) begin
      case (r_state)
        RISE: w_shadow_next = w_rise_top ? MAX_N : w_sum[PWM_BITS-1:0];
        FALL: begin
          w_shadow_next     = w_fall_bottom ? '0 : (r_shadow - STEP_N);
          w_cycle_done_next = w_fall_bottom;
        end
        default: w_shadow_next = r_shadow;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shadow     <= '0;
      r_cycle_done <= 1'b0;
    end else begin
      r_shadow     <= w_shadow_next;
      r_cycle_done <= w_cycle_done_next;
    end
  end

  led_pwm_gen #(
    .PWM_BITS  (PWM_BITS),
    .ACTIVE_LOW(ACTIVE_LOW)
  ) u_pwm (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (en),
    .i_shadow(r_shadow),
    .o_duty  (duty),
    .o_led   (led_out)
  );

  assign cycle_done = r_cycle_done;

endmodule

// File: tb/tb_led_breath.sv
// tb_led_breath -- directed bench for led_breath (PWM_BITS=4, STEP=4,
// HOLD_TICKS=2, ACTIVE_LOW=1). Covers both builds of LED_BREATH_HOLD_EN.
module tb_led_breath;
  import led_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       tick_in;
  logic       led_out;
  logic [3:0] duty;
  logic       cycle_done;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  led_breath #(
    .PWM_BITS  (4),
    .STEP      (4),
    .HOLD_TICKS(2),
    .ACTIVE_LOW(1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .tick_in   (tick_in),
    .led_out   (led_out),
    .duty      (duty),
    .cycle_done(cycle_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_tick();
    tick_in = 1'b1;
    @(negedge clk);
    tick_in = 1'b0;
  endtask

  // Bounded wait for the PWM counter to reach a value (sampled on negedge).
  task automatic wait_cnt(input int v);
    for (int k = 0; k < 40; k++) begin
      if (32'(dut.u_pwm.r_cnt) == v) return;
      @(negedge clk);
    end
    chk("wait_cnt_timeout", 32'(dut.u_pwm.r_cnt), 32'(v));
  endtask

  // One tick of the ramp: shadow update, cycle_done level, duty held until the
  // wrap, duty loaded at pwm_cnt=0, and lit (low) clocks over the next period.
  task automatic breath_step(input string tag, input int new_d, input int old_d,
                             input logic exp_done);
    int lows;
    do_tick();
    chk({tag, "_shadow"}, 32'(dut.r_shadow), 32'(new_d));
    chk({tag, "_cycle_done"}, 32'(cycle_done), 32'(exp_done));
    step();
    chk({tag, "_cycle_done_off"}, 32'(cycle_done), 32'd0);
    wait_cnt(15);
    chk({tag, "_duty_hold"}, 32'(duty), 32'(old_d));
    step();
    chk({tag, "_wrap_cnt"}, 32'(dut.u_pwm.r_cnt), 32'd0);
    chk({tag, "_duty_load"}, 32'(duty), 32'(new_d));
    lows = 0;
    repeat (16) begin
      step();
      if (led_out == 1'b0) lows++;
    end
    chk({tag, "_lit_clocks"}, 32'(lows), 32'(new_d));
    $display("step %s: shadow=%0d duty=%0d lit_clocks=%0d", tag, dut.r_shadow, duty, lows);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cd_count;

    // Reset overrides an asserted en and tick_in.
    rst_n   = 1'b0;
    en      = 1'b1;
    tick_in = 1'b1;
    step(3);
    tick_in = 1'b0;
    chk("rst_led_out", 32'(led_out), 32'd1);
    chk("rst_duty", 32'(duty), 32'd0);
    chk("rst_cycle_done", 32'(cycle_done), 32'd0);
    chk("rst_state", 32'(dut.r_state), 32'(IDLE));
    chk("rst_shadow", 32'(dut.r_shadow), 32'd0);
    $display("reset: led_out=%0d duty=%0d cycle_done=%0d", led_out, duty, cycle_done);

    rst_n = 1'b1;
    step();
    chk("start_state", 32'(dut.r_state), 32'(RISE));

    // Rise, saturating at 15.
    breath_step("rise1", 4, 0, 1'b0);
    breath_step("rise2", 8, 4, 1'b0);
    breath_step("rise3", 12, 8, 1'b0);
    breath_step("rise4", 15, 12, 1'b0);
`ifdef LED_BREATH_HOLD_EN
    chk("top_state", 32'(dut.r_state), 32'(HOLD_HI));
    do_tick();
    chk("hold_hi1_state", 32'(dut.r_state), 32'(HOLD_HI));
    chk("hold_hi1_duty", 32'(duty), 32'd15);
    do_tick();
    chk("hold_hi2_state", 32'(dut.r_state), 32'(FALL));
    chk("hold_hi2_shadow", 32'(dut.r_shadow), 32'd15);
    $display("hold_hi: two ticks, state=%0d", dut.r_state);
`else
    chk("top_state", 32'(dut.r_state), 32'(FALL));
`endif

    // Fall, floored at 0, cycle_done on the last step.
    breath_step("fall1", 11, 15, 1'b0);
    breath_step("fall2", 7, 11, 1'b0);
    breath_step("fall3", 3, 7, 1'b0);
    breath_step("fall4", 0, 3, 1'b1);
`ifdef LED_BREATH_HOLD_EN
    chk("bottom_state", 32'(dut.r_state), 32'(HOLD_LO));
    do_tick();
    chk("hold_lo1_state", 32'(dut.r_state), 32'(HOLD_LO));
    chk("hold_lo1_cycle_done", 32'(cycle_done), 32'd0);
    do_tick();
    chk("hold_lo2_state", 32'(dut.r_state), 32'(RISE));
    chk("hold_lo2_shadow", 32'(dut.r_shadow), 32'd0);
    $display("hold_lo: two ticks, state=%0d", dut.r_state);
`else
    chk("bottom_state", 32'(dut.r_state), 32'(RISE));
`endif

    // en dropped mid-period at duty 8.
    breath_step("re1", 4, 0, 1'b0);
    breath_step("re2", 8, 4, 1'b0);
    wait_cnt(5);
    chk("pre_drop_led", 32'(led_out), 32'd0);
    en = 1'b0;
    step();
    chk("drop_led", 32'(led_out), 32'd1);
    chk("drop_duty", 32'(duty), 32'd0);
    chk("drop_shadow", 32'(dut.r_shadow), 32'd0);
    chk("drop_state", 32'(dut.r_state), 32'(IDLE));
    chk("drop_cnt", 32'(dut.u_pwm.r_cnt), 32'd0);
    do_tick();
    chk("idle_tick_shadow", 32'(dut.r_shadow), 32'd0);
    chk("idle_tick_state", 32'(dut.r_state), 32'(IDLE));
    $display("en drop: led_out=%0d duty=%0d", led_out, duty);
    en = 1'b1;
    step();
    chk("reen_state", 32'(dut.r_state), 32'(RISE));
    cd_count = 0;
    repeat (40) begin
      step();
      if (cycle_done) cd_count++;
    end
    chk("reen_no_cycle_done", 32'(cd_count), 32'd0);
    chk("reen_shadow", 32'(dut.r_shadow), 32'd0);

    // Tick landing in the wrap cycle: old duty for one more period.
    wait_cnt(0);
    breath_step("w1", 4, 0, 1'b0);
    wait_cnt(15);
    do_tick();
    chk("wrap_tick_cnt", 32'(dut.u_pwm.r_cnt), 32'd0);
    chk("wrap_tick_shadow", 32'(dut.r_shadow), 32'd8);
    chk("wrap_tick_duty_old", 32'(duty), 32'd4);
    step(15);
    chk("wrap_tick_duty_still", 32'(duty), 32'd4);
    step();
    chk("wrap_tick_duty_new", 32'(duty), 32'd8);
    $display("wrap tick: duty=%0d after next wrap", duty);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/led_breath.md
LED_BREATH -- requirements
Module: led_breath

Interface
REQ-001 SHALL have parameter PWM_BITS, default 8: width of the PWM counter and the duty value, giving a period of 2^PWM_BITS clocks.
REQ-002 SHALL have parameter STEP, default 1: amount the duty changes on each accepted tick.
REQ-003 SHALL have parameter HOLD_TICKS, default 4: ticks spent at each extreme; used only when LED_BREATH_HOLD_EN is defined.
REQ-004 SHALL have parameter ACTIVE_LOW, default 1: when 1, the LED is lit with led_out=0.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port en, input, 1 bit: enables breathing; low forces idle.
REQ-008 SHALL have port tick_in, input, 1 bit: one-cycle step pulse from the upstream interval counter.
REQ-009 SHALL have port led_out, output, 1 bit: registered PWM drive to the LED pin.
REQ-010 SHALL have port duty, output, PWM_BITS bits: the duty value currently applied.
REQ-011 SHALL have port cycle_done, output, 1 bit: one-cycle pulse at the end of each complete breath (rise then fall).

Function
REQ-012 SHALL run pwm_cnt 0 to 2^PWM_BITS-1 and wrap to 0, incrementing every clock while en=1.
REQ-013 SHALL compute lit = (pwm_cnt < duty) and drive led_out = lit XOR ACTIVE_LOW, registered, one clock after the compare.
REQ-014 SHALL update duty_shadow on a tick; SHALL load duty (the applied value) from duty_shadow only in the cycle pwm_cnt wraps to 0, so no period ever sees two duty values.
REQ-015 SHALL ignore a tick in the wrap cycle for the current load; the updated shadow applies from the next wrap.
REQ-016 SHALL use FSM states IDLE, RISE, HOLD_HI, FALL, HOLD_LO.
REQ-017 SHALL go IDLE -> RISE on the first clock with en=1.
REQ-018 SHALL, in RISE on a tick, set shadow = min(shadow+STEP, MAX), where MAX = 2^PWM_BITS-1 and the addition is computed one bit wider with no wrap; on reaching MAX it SHALL leave RISE in the same cycle.
REQ-019 SHALL, in FALL on a tick, set shadow = max(shadow-STEP, 0) with no underflow; on reaching 0 it SHALL leave FALL in the same cycle and pulse cycle_done for one clock in the following cycle.
REQ-020 SHALL hold the LED fully off at duty=0 and lit for MAX of 2^PWM_BITS clocks at duty=MAX.
REQ-021 SHALL, whenever en=0 (including mid-breath), on the next clock set the state to IDLE, pwm_cnt=0, shadow=0, duty=0, led_out to the off level and cycle_done=0; ticks while en=0 SHALL be ignored.
REQ-022 SHALL treat tick_in held high as one tick per clock with no edge detection.

Reset
REQ-023 SHALL, while rst_n=0 at a clock edge, set state=IDLE, pwm_cnt=0, shadow=0, duty=0, hold counter=0, cycle_done=0 and led_out=ACTIVE_LOW (off); reset SHALL override en and tick_in.
REQ-024 SHALL start a fresh rise after reset is released mid-breath, with no memory of the earlier phase.

Configuration
REQ-025 SHALL, with LED_BREATH_HOLD_EN defined, route RISE -> HOLD_HI -> FALL and FALL -> HOLD_LO -> RISE, each hold state staying HOLD_TICKS ticks (a counter from 0 to HOLD_TICKS-1, then exit on that tick); cycle_done SHALL pulse on the exit from FALL.
REQ-026 SHALL, without LED_BREATH_HOLD_EN, go RISE -> FALL and FALL -> RISE directly, with no hold states or hold counter synthesized and HOLD_TICKS ignored.

Structure
REQ-027 SHALL place the FSM state typedef and the off-level and duty-limit constants in a shared package, led_pkg.
REQ-028 SHALL implement pwm_cnt, the compare and the duty load-on-wrap in one sub-module, led_pwm_gen; the FSM, shadow update and hold counter SHALL stay in led_breath.

Verification (PWM_BITS=4, STEP=4, ACTIVE_LOW=1, tick every 32 clocks)
REQ-029 SHALL check reset: rst_n=0 for 3 clocks -> led_out=1, duty=0, cycle_done=0; after release with en=1 -> state RISE.
REQ-030 SHALL check the rise: ticks give shadow 4, 8, 12, 15 (saturated, not 16); each new duty appears only at pwm_cnt=0; at duty=8 there are 8 low clocks per 16.
REQ-031 SHALL check the full cycle without the macro: 15 -> 11 -> 7 -> 3 -> 0 (floored), then one cycle_done pulse, then RISE.
REQ-032 SHALL check the full cycle with LED_BREATH_HOLD_EN and HOLD_TICKS=2: exactly 2 ticks at duty 15 and 2 ticks at 0; a tick in the second hold tick of HOLD_LO enters RISE.
REQ-033 SHALL check en dropped at shadow=8 mid-period -> next clock led_out=1, duty=0; re-raising en restarts from 0 with no cycle_done.
REQ-034 SHALL check a tick in the wrap cycle -> duty keeps its old value for that period and the new value appears 16 clocks later.
